ps2_mouse_tx: RTL and testbench
===============================

PS2_MOUSE_TX -- requirements
Module: ps2_mouse_tx

Interface
REQ-001 SHALL have parameter HALF_CYC, default 8, clk_sys cycles per PS/2 clock half-period (legal range 2..65535).
REQ-002 SHALL have parameter GAP_CYC, default 16, clk_sys cycles of idle line between bytes of a packet (legal range 1..65535).
REQ-003 SHALL have port clk_sys  input  1  system clock; all state on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port ps2_mouse  input  25  host packet: [7:0] status, [15:8] dX, [23:16] dY, [24] toggles once per new packet.
REQ-006 SHALL have port ps2_mouse_clk  output  1  emulated PS/2 clock line, registered.
REQ-007 SHALL have port ps2_mouse_data  output  1  emulated PS/2 data line, registered.
REQ-008 SHALL have port busy  output  1  high while any packet bit or inter-byte gap is in progress.
REQ-009 SHALL have port merged  output  1  one-cycle pulse when an arriving packet is merged into an already-pending packet.

Function
REQ-010 New packet detected when ps2_mouse[24] differs from its registered copy; detection cycle = cycle after the change is sampled.
REQ-011 First clk_sys cycle after reset release only loads the toggle copy; no packet is generated from the reset-time toggle value.
REQ-012 Each packet transmitted as three bytes in order status, dX, dY.
REQ-013 Each byte is an 11-bit frame: start 0, data bits 0..7 LSB first, odd parity (~^byte), stop 1.
REQ-014 Each bit: phase H (clk=1, data=bit value, HALF_CYC cycles), then phase L (clk=0, data held, HALF_CYC cycles); data changes only at H-phase entry.
REQ-015 After a byte's stop-bit L phase: clk=1, data=1 for GAP_CYC cycles before the next byte's start-bit H phase; no gap after the third byte.
REQ-016 After the third byte's stop-bit L phase, return to IDLE with clk=1, data=1; that final rising clk edge completes the 33-bit frame for the downstream decoder.
REQ-017 FSM states IDLE, BIT_H, BIT_L, GAP; counters: half-period counter, bit index 0..10, byte index 0..2.
REQ-018 IDLE with packet available -> BIT_H of byte 0 start bit on the next cycle (ps2_mouse_data=0 one cycle after detection when idle).
REQ-019 One pending-packet buffer; a packet detected while busy is stored there and transmitted immediately after the current packet's IDLE cycle.
REQ-020 Packet detected while pending already full: merge into pending, pulse merged for one cycle.
REQ-021 Merge: dX, dY treated as 9-bit signed (sign = status bit 4 / bit 5 resp.), summed, saturated to -256..+255; resulting sign bits and low 8 bits rewritten into status/dX/dY.
REQ-022 Merge: status bits 2:0 (buttons) and bit 3 from the newer packet; bits 7:6 (overflow) = OR of both, additionally set for an axis whose sum saturated.
REQ-023 Packet detected in the same cycle the pending buffer is consumed: new packet becomes the pending content (no merge, no pulse).
REQ-024 Packet under transmission is latched at frame start and never altered mid-frame.
REQ-025 busy=0 only in IDLE with pending empty.

Reset
REQ-026 reset_n low asynchronously forces: state IDLE, ps2_mouse_clk=1, ps2_mouse_data=1, busy=0, merged=0, pending empty, counters 0.
REQ-027 Reset asserted mid-packet aborts it immediately; partial frame discarded; no retransmission after release.

Verification
REQ-028 Toggle with packet {8'h00,8'h05,8'h09} -> 33 bits start/9'h109 byte0 ... line sequence 0,1,0,0,1,0,0,0,0,1(parity),1; decoder model reports buttons=1, dX=+5, dY=0.
REQ-029 HALF_CYC=8, GAP_CYC=16 -> clk low pulses exactly 8 cycles, packet duration 33*16+2*16=560 cycles from first H entry to IDLE.
REQ-030 Three toggles 2 cycles apart during a packet with dX +200, +100 -> second packet dX=+255, status bit 6 set, merged pulse once.
REQ-031 Merge of dY -200 and -100 -> dY byte 8'h00, status bit 5=1, bit 7=1 (saturated -256).
REQ-032 Reset_n low at bit 5 of byte 1 -> clk and data high within same cycle, busy=0; after release with static toggle=1, no traffic.
REQ-033 Two toggles separated by full idle -> two identical-timed packets, merged never asserted, busy drops between them.

Source files
------------

// File: rtl/ps2_mouse_tx.sv
// Emulates a PS/2 mouse transmitter: a 3-byte packet from the host becomes three
// 11-bit frames on registered clock/data lines, with one pending slot that merges overflow packets.
module ps2_mouse_tx #(
  parameter int HALF_CYC = 8,
  parameter int GAP_CYC  = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [24:0] ps2_mouse,
  output logic        ps2_mouse_clk,
  output logic        ps2_mouse_data,
  output logic        busy,
  output logic        merged
);

  // state | meaning
  // IDLE  | lines released, waiting for a detected or pending packet
  // BIT_H | clock high half of a bit, data just updated
  // BIT_L | clock low half of a bit, data held
  // GAP   | idle line between two bytes of one packet
  typedef enum logic [1:0] {IDLE, BIT_H, BIT_L, GAP} state_t;

  localparam logic [15:0] HALF_LD = 16'(HALF_CYC - 1);
  localparam logic [15:0] GAP_LD  = 16'(GAP_CYC - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [3:0]  bit_idx, bit_nxt;
  logic [1:0]  byte_idx, byte_nxt;
  logic [23:0] cur, cur_nxt;
  logic        clk_nxt, data_nxt;
  logic        tog_q, armed, det;
  logic [23:0] det_pkt;
  logic        pend_valid;
  logic [23:0] pend;
  logic        consume, to_pend;

  function automatic logic frame_bit(input logic [23:0] pkt, input logic [1:0] byte_i,
                                     input logic [3:0] bit_i);
    logic [7:0] b;
    logic [2:0] k;
    b = (byte_i == 2'd0) ? pkt[7:0] : (byte_i == 2'd1) ? pkt[15:8] : pkt[23:16];
    k = 3'(bit_i - 4'd1);
    case (bit_i)
      4'd0:    frame_bit = 1'b0;
      4'd9:    frame_bit = ~^b;
      4'd10:   frame_bit = 1'b1;
      default: frame_bit = b[k];
    endcase
  endfunction

  // 10-bit sum of two 9-bit values: bits 9 and 8 disagree exactly when the result leaves -256..255
  function automatic logic [23:0] merge_pkt(input logic [23:0] old_p, input logic [23:0] new_p);
    logic [9:0] sx, sy;
    logic [8:0] rx, ry;
    logic       sat_x, sat_y;
    sx    = {{2{old_p[4]}}, old_p[15:8]} + {{2{new_p[4]}}, new_p[15:8]};
    sy    = {{2{old_p[5]}}, old_p[23:16]} + {{2{new_p[5]}}, new_p[23:16]};
    sat_x = sx[9] ^ sx[8];
    sat_y = sy[9] ^ sy[8];
    rx    = sat_x ? (sx[9] ? 9'h100 : 9'h0ff) : sx[8:0];
    ry    = sat_y ? (sy[9] ? 9'h100 : 9'h0ff) : sy[8:0];
    merge_pkt = {ry[7:0], rx[7:0], old_p[7] | new_p[7] | sat_y, old_p[6] | new_p[6] | sat_x,
                 ry[8], rx[8], new_p[3:0]};
  endfunction

  // armed stays low for the first cycle after reset so the reset-time toggle value is not a packet
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tog_q   <= 1'b0;
      armed   <= 1'b0;
      det     <= 1'b0;
      det_pkt <= 24'd0;
    end else begin
      tog_q   <= ps2_mouse[24];
      armed   <= 1'b1;
      det     <= armed & (ps2_mouse[24] ^ tog_q);
      det_pkt <= ps2_mouse[23:0];
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    byte_nxt  = byte_idx;
    cur_nxt   = cur;
    clk_nxt   = ps2_mouse_clk;
    data_nxt  = ps2_mouse_data;
    consume   = 1'b0;
    case (state)
      IDLE: begin
        if (pend_valid || det) begin
          consume   = pend_valid;
          cur_nxt   = pend_valid ? pend : det_pkt;
          state_nxt = BIT_H;
          cnt_nxt   = HALF_LD;
          bit_nxt   = 4'd0;
          byte_nxt  = 2'd0;
          clk_nxt   = 1'b1;
          data_nxt  = 1'b0;
        end
      end
      BIT_H: begin
        if (cnt == 16'd0) begin
          state_nxt = BIT_L;
          cnt_nxt   = HALF_LD;
          clk_nxt   = 1'b0;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      BIT_L: begin
        if (cnt == 16'd0) begin
          clk_nxt = 1'b1;
          if (bit_idx == 4'd10) begin
            bit_nxt  = 4'd0;
            data_nxt = 1'b1;
            if (byte_idx == 2'd2) begin
              state_nxt = IDLE;
              byte_nxt  = 2'd0;
              cnt_nxt   = 16'd0;
            end else begin
              state_nxt = GAP;
              byte_nxt  = byte_idx + 2'd1;
              cnt_nxt   = GAP_LD;
            end
          end else begin
            state_nxt = BIT_H;
            bit_nxt   = bit_idx + 4'd1;
            cnt_nxt   = HALF_LD;
            data_nxt  = frame_bit(cur, byte_idx, bit_idx + 4'd1);
          end
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      GAP: begin
        if (cnt == 16'd0) begin
          state_nxt = BIT_H;
          cnt_nxt   = HALF_LD;
          data_nxt  = frame_bit(cur, byte_idx, 4'd0);
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= 16'd0;
      bit_idx        <= 4'd0;
      byte_idx       <= 2'd0;
      cur            <= 24'd0;
      ps2_mouse_clk  <= 1'b1;
      ps2_mouse_data <= 1'b1;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      bit_idx        <= bit_nxt;
      byte_idx       <= byte_nxt;
      cur            <= cur_nxt;
      ps2_mouse_clk  <= clk_nxt;
      ps2_mouse_data <= data_nxt;
    end
  end

  // an idle line with nothing pending starts the detected packet directly instead of queueing it
  assign to_pend = det & ~((state == IDLE) & ~pend_valid);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid <= 1'b0;
      pend       <= 24'd0;
      merged     <= 1'b0;
    end else begin
      merged <= 1'b0;
      if (to_pend) begin
        if (!pend_valid || consume) begin
          pend       <= det_pkt;
          pend_valid <= 1'b1;
        end else begin
          pend   <= merge_pkt(pend, det_pkt);
          merged <= 1'b1;
        end
      end else if (consume) begin
        pend_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE) | pend_valid;

endmodule

// File: tb/tb_ps2_mouse_tx.sv
// Bench for ps2_mouse_tx: a line decoder feeds a scoreboard of packets predicted by an
// arithmetic merge model; random bursts plus directed merge, saturation and reset cases.
module tb_ps2_mouse_tx;
  localparam int HALF = 8;
  localparam int GAP = 16;
  localparam int PKT_CYC = 33 * 2 * HALF + 2 * GAP;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [24:0] ps2_mouse = 25'h1000000;
  logic        ps2_mouse_clk, ps2_mouse_data, busy, merged;

  ps2_mouse_tx #(.HALF_CYC(HALF), .GAP_CYC(GAP)) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .ps2_mouse(ps2_mouse),
    .ps2_mouse_clk(ps2_mouse_clk),
    .ps2_mouse_data(ps2_mouse_data),
    .busy(busy),
    .merged(merged)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad = 0;
  logic [23:0] exp_q[$];
  logic [23:0] burst_q[$];
  int merged_cnt = 0;
  int low_samples = 0;
  int frames = 0;
  logic [23:0] last_pkt = 24'd0;
  bit mdl_active = 1'b0;
  bit mdl_has_pend = 1'b0;
  logic [23:0] mdl_pend = 24'd0;
  int exp_merges = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // reference merge: plain signed integer arithmetic with clamping
  function automatic logic [23:0] model_merge(input logic [23:0] a, input logic [23:0] b);
    int ax, ay, bx, by, sx, sy;
    bit ovx, ovy;
    logic [7:0] st;
    ax = int'(a[15:8]) - (a[4] ? 256 : 0);
    ay = int'(a[23:16]) - (a[5] ? 256 : 0);
    bx = int'(b[15:8]) - (b[4] ? 256 : 0);
    by = int'(b[23:16]) - (b[5] ? 256 : 0);
    sx = ax + bx;
    sy = ay + by;
    ovx = 1'b0;
    ovy = 1'b0;
    if (sx > 255) begin sx = 255; ovx = 1'b1; end
    else if (sx < -256) begin sx = -256; ovx = 1'b1; end
    if (sy > 255) begin sy = 255; ovy = 1'b1; end
    else if (sy < -256) begin sy = -256; ovy = 1'b1; end
    st = {a[7] | b[7] | ovy, a[6] | b[6] | ovx, sy < 0, sx < 0, b[3:0]};
    return {8'(sy & 255), 8'(sx & 255), st};
  endfunction

  // line decoder: samples on the falling clk_sys edge, takes a bit at every falling PS/2 clock
  bit prev_clk = 1'b1;
  bit in_frame = 1'b0;
  int nbits = 0;
  int low_len = 0;
  int cyc = 0;
  int t0 = 0;
  logic [32:0] bits = 33'd0;

  task automatic decode_frame(input int dur);
    logic [7:0] b [3];
    logic [23:0] got;
    chk("pkt_duration", dur, PKT_CYC);
    for (int k = 0; k < 3; k++) begin
      b[k] = bits[11 * k + 1 +: 8];
      chk("start_bit", bits[11 * k], 1'b0);
      chk("parity_bit", bits[11 * k + 9], ~^b[k]);
      chk("stop_bit", bits[11 * k + 10], 1'b1);
    end
    got = {b[2], b[1], b[0]};
    last_pkt = got;
    frames++;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_packet got=%06h want=none", got);
    end else begin
      chk("packet", got, exp_q.pop_front());
    end
    in_frame = 1'b0;
    nbits = 0;
  endtask

  initial begin
    forever begin
      @(negedge clk_sys);
      cyc++;
      if (!reset_n) begin
        in_frame = 1'b0;
        nbits = 0;
        prev_clk = 1'b1;
        low_len = 0;
      end else begin
        if (merged) merged_cnt++;
        if (!ps2_mouse_clk) low_samples++;
        if (!in_frame && ps2_mouse_clk && !ps2_mouse_data) begin
          in_frame = 1'b1;
          t0 = cyc;
          nbits = 0;
        end
        if (prev_clk && !ps2_mouse_clk) begin
          if (nbits < 33) bits[nbits] = ps2_mouse_data;
          nbits++;
          low_len = 0;
        end
        if (!ps2_mouse_clk) low_len++;
        if (!prev_clk && ps2_mouse_clk) begin
          chk("clk_low_len", low_len, HALF);
          if (nbits == 33) decode_frame(cyc - t0);
        end
        prev_clk = ps2_mouse_clk;
      end
    end
  end

  task automatic issue(input logic [23:0] pkt);
    @(posedge clk_sys);
    #1;
    ps2_mouse = {~ps2_mouse[24], pkt};
    if (!mdl_active) begin
      exp_q.push_back(pkt);
      mdl_active = 1'b1;
    end else if (!mdl_has_pend) begin
      mdl_pend = pkt;
      mdl_has_pend = 1'b1;
    end else begin
      mdl_pend = model_merge(mdl_pend, pkt);
      exp_merges++;
    end
  endtask

  task automatic close_burst();
    if (mdl_has_pend) exp_q.push_back(mdl_pend);
    mdl_has_pend = 1'b0;
    mdl_active = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    repeat (4) @(negedge clk_sys);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_sys);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL busy_timeout got=busy want=idle");
    end
    repeat (4) @(negedge clk_sys);
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  // issues every packet of burst_q 2..6 cycles apart, all inside the first packet's frame
  task automatic run_burst();
    int m0;
    m0 = merged_cnt;
    exp_merges = 0;
    while (burst_q.size() > 0) begin
      issue(burst_q.pop_front());
      repeat ($urandom_range(1, 5)) @(posedge clk_sys);
    end
    close_burst();
    wait_idle();
    chk("merged_pulses", merged_cnt - m0, exp_merges);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ls, fr, m0, k;
    #23;
    chk("reset_clk", ps2_mouse_clk, 1'b1);
    chk("reset_data", ps2_mouse_data, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_merged", merged, 1'b0);
    @(posedge clk_sys);
    #2 reset_n = 1'b1;
    repeat (50) @(posedge clk_sys);
    chk("no_pkt_from_reset_toggle", low_samples, 0);

    burst_q.push_back(24'h000509);
    run_burst();
    chk("decode_buttons", last_pkt[2:0], 3'd1);
    chk("decode_dx", last_pkt[15:8], 8'd5);
    chk("decode_dy", last_pkt[23:16], 8'd0);

    burst_q.push_back(24'($urandom));
    burst_q.push_back(24'h00c808);
    burst_q.push_back(24'h006408);
    run_burst();
    chk("merge_x_saturate", last_pkt, 24'h00ff48);

    burst_q.push_back(24'($urandom));
    burst_q.push_back(24'h380028);
    burst_q.push_back(24'h9c0028);
    run_burst();
    chk("merge_y_saturate", last_pkt, 24'h0000a8);

    m0 = merged_cnt;
    fr = frames;
    burst_q.push_back(24'($urandom));
    run_burst();
    burst_q.push_back(24'($urandom));
    run_burst();
    chk("separate_frames", frames - fr, 2);
    chk("separate_no_merge", merged_cnt - m0, 0);

    issue(24'($urandom));
    close_burst();
    repeat (276) @(posedge clk_sys);
    #2 reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_clk", ps2_mouse_clk, 1'b1);
    chk("abort_data", ps2_mouse_data, 1'b1);
    chk("abort_busy", busy, 1'b0);
    repeat (3) @(posedge clk_sys);
    #2 reset_n = 1'b1;
    ls = low_samples;
    fr = frames;
    repeat (800) @(posedge clk_sys);
    chk("abort_no_traffic", low_samples - ls, 0);
    chk("abort_no_frames", frames - fr, 0);

    for (int b = 0; b < 15; b++) begin
      k = $urandom_range(1, 4);
      for (int i = 0; i < k; i++) burst_q.push_back(24'($urandom));
      run_burst();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
